// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module   : irq_ctrl_pkg
// Brief    : Shared state encoding and index helper for the interrupt sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } irq_state_e;

  // Flat position of (group, channel) in the request/pending vectors
  function automatic int flat_idx(input int grp, input int chan, input int chans);
    return grp * chans + chan;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module   : irq_prio_enc
// Brief    : Fixed-priority encoder: lowest group wins, highest channel within it
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_GROUPS = 3,
  parameter int CHANS      = 9,
  parameter int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  parameter int CHN_W      = (CHANS > 1) ? $clog2(CHANS) : 1
) (
  input  logic [NUM_GROUPS*CHANS-1:0] eligible,
  output logic                        any,
  output logic [GRP_W-1:0]            group,
  output logic [CHN_W-1:0]            chan
);

  logic [NUM_GROUPS-1:0]            w_grp_any;
  logic [NUM_GROUPS-1:0][CHN_W-1:0] w_grp_chan;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    logic [CHN_W-1:0] w_sel;

    // Ascending scan so the highest set channel is the last one kept
    always_comb begin
      w_sel = '0;
      for (int c = 0; c < CHANS; c++) begin
        if (eligible[g*CHANS + c]) w_sel = CHN_W'(c);
      end
    end

    assign w_grp_any[g]  = |eligible[g*CHANS +: CHANS];
    assign w_grp_chan[g] = w_sel;
  end

  always_comb begin
    any   = |w_grp_any;
    group = '0;
    chan  = '0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (w_grp_any[g]) begin
        group = GRP_W'(g);
        chan  = w_grp_chan[g];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl_seq.sv
// ============================================================================
// Module   : irq_ctrl_seq
// Brief    : Clocked priority interrupt controller with valid/ack presentation
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl_seq
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_GROUPS = 3,
  parameter int CHANS      = 9,
  parameter int EDGE_MODE  = 1,
  parameter int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  parameter int CHN_W      = (CHANS > 1) ? $clog2(CHANS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANS-1:0]            en,
  input  logic [NUM_GROUPS*CHANS-1:0] req,
  input  logic                        irq_ack,
  output logic                        irq_valid,
  output logic [GRP_W-1:0]            irq_group,
  output logic [CHN_W-1:0]            irq_chan,
  output logic [NUM_GROUPS-1:0]       grp_active,
  output logic [NUM_GROUPS*CHANS-1:0] pending
);

  localparam int c_NUM_BITS = NUM_GROUPS * CHANS;

  irq_state_e              r_state, w_state_nxt;
  logic [c_NUM_BITS-1:0]   r_req_q, r_pending, w_pending_nxt, w_clr, w_eligible;
  logic [NUM_GROUPS-1:0]   r_grp_active, w_grp_active_nxt;
  logic                    r_irq_valid, w_valid_nxt;
  logic [GRP_W-1:0]        r_irq_group, w_group_nxt, w_win_grp;
  logic [CHN_W-1:0]        r_irq_chan, w_chan_nxt, w_win_chan;
  logic                    w_any, w_ack_take;

  assign w_ack_take = (r_state == GRANT) && irq_ack;

  always_comb begin
    w_clr = '0;
    for (int b = 0; b < c_NUM_BITS; b++) begin
      if (w_ack_take && (b == flat_idx(int'(r_irq_group), int'(r_irq_chan), CHANS)))
        w_clr[b] = 1'b1;
    end
  end

  // Set is OR'ed in after the clear so a fresh edge survives a same-cycle ack
  if (EDGE_MODE != 0) begin : g_edge
    assign w_pending_nxt = (r_pending & ~w_clr) | (req & ~r_req_q);
  end else begin : g_level
    assign w_pending_nxt = req;
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_elig
    assign w_eligible[g*CHANS +: CHANS] = r_pending[g*CHANS +: CHANS] & en;
    assign w_grp_active_nxt[g]          = |w_eligible[g*CHANS +: CHANS];
  end

  irq_prio_enc #(
    .NUM_GROUPS (NUM_GROUPS),
    .CHANS      (CHANS),
    .GRP_W      (GRP_W),
    .CHN_W      (CHN_W)
  ) u_prio_enc (
    .eligible (w_eligible),
    .any      (w_any),
    .group    (w_win_grp),
    .chan     (w_win_chan)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_irq_valid;
    w_group_nxt = r_irq_group;
    w_chan_nxt  = r_irq_chan;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_valid_nxt = 1'b1;
          w_group_nxt = w_win_grp;
          w_chan_nxt  = w_win_chan;
        end
      end
      GRANT: begin
        if (irq_ack) begin
          w_state_nxt = GAP;
          w_valid_nxt = 1'b0;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_q      <= '0;
      r_pending    <= '0;
      r_grp_active <= '0;
      r_irq_valid  <= 1'b0;
      r_irq_group  <= '0;
      r_irq_chan   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_q      <= req;
      r_pending    <= w_pending_nxt;
      r_grp_active <= w_grp_active_nxt;
      r_irq_valid  <= w_valid_nxt;
      r_irq_group  <= w_group_nxt;
      r_irq_chan   <= w_chan_nxt;
    end
  end

  assign irq_valid  = r_irq_valid;
  assign irq_group  = r_irq_group;
  assign irq_chan   = r_irq_chan;
  assign grp_active = r_grp_active;
  assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl_seq.sv
// ============================================================================
// Module   : tb_irq_ctrl_seq
// Brief    : Edge-mode and level-mode instances against a cycle reference model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl_seq;

  localparam int NG = 3;
  localparam int CH = 9;
  localparam int NB = NG * CH;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic [NB-1:0] req_e, req_l;
  logic          ack_e, ack_l;

  logic          valid_e, valid_l;
  logic [1:0]    grp_e, grp_l;
  logic [3:0]    chn_e, chn_l;
  logic [NG-1:0] gact_e, gact_l;
  logic [NB-1:0] pend_e, pend_l;

  int checks = 0;
  int errors = 0;

  irq_ctrl_seq #(.NUM_GROUPS(NG), .CHANS(CH), .EDGE_MODE(1)) u_dut_edge (
    .clk(clk), .rst(rst), .en(en), .req(req_e), .irq_ack(ack_e),
    .irq_valid(valid_e), .irq_group(grp_e), .irq_chan(chn_e),
    .grp_active(gact_e), .pending(pend_e)
  );

  irq_ctrl_seq #(.NUM_GROUPS(NG), .CHANS(CH), .EDGE_MODE(0)) u_dut_level (
    .clk(clk), .rst(rst), .en(en), .req(req_l), .irq_ack(ack_l),
    .irq_valid(valid_l), .irq_group(grp_l), .irq_chan(chn_l),
    .grp_active(gact_l), .pending(pend_l)
  );

  always #5 clk = ~clk;

  // Reference model, index 0 = edge instance, 1 = level instance
  logic [NB-1:0] m_pend [2];
  logic [NB-1:0] m_reqq [2];
  logic [NG-1:0] m_gact [2];
  bit            m_busy [2];   // presenting an interrupt
  bit            m_gap  [2];   // mandatory low cycle after an ack
  int            m_grp  [2];
  int            m_chn  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k, input logic [NB-1:0] rq, input logic ack);
    logic [NB-1:0] elig, nxt;
    bit found;
    int wg, wc;
    if (rst) begin
      m_pend[k] = '0; m_reqq[k] = '0; m_gact[k] = '0;
      m_busy[k] = 0;  m_gap[k]  = 0;  m_grp[k]  = 0; m_chn[k] = 0;
      return;
    end
    elig  = m_pend[k] & {NG{en}};
    found = 0; wg = 0; wc = 0;
    for (int g = 0; g < NG; g++)
      for (int c = CH - 1; c >= 0; c--)
        if (!found && elig[g*CH + c]) begin found = 1; wg = g; wc = c; end
    if (k == 0) begin
      nxt = m_pend[k];
      if (m_busy[k] && ack) nxt[m_grp[k]*CH + m_chn[k]] = 1'b0;
      nxt = nxt | (rq & ~m_reqq[k]);
    end else begin
      nxt = rq;
    end
    if (m_busy[k]) begin
      if (ack) begin m_busy[k] = 0; m_gap[k] = 1; end
    end else if (m_gap[k]) begin
      m_gap[k] = 0;
    end else if (found) begin
      m_busy[k] = 1; m_grp[k] = wg; m_chn[k] = wc;
    end
    for (int g = 0; g < NG; g++) m_gact[k][g] = |elig[g*CH +: CH];
    m_pend[k] = nxt;
    m_reqq[k] = rq;
  endtask

  task automatic step();
    model_step(0, req_e, ack_e);
    model_step(1, req_l, ack_l);
    @(posedge clk);
    #1;
    chk("e_valid", 32'(valid_e), 32'(m_busy[0]));
    chk("e_group", 32'(grp_e),   m_grp[0]);
    chk("e_chan",  32'(chn_e),   m_chn[0]);
    chk("e_gact",  32'(gact_e),  32'(m_gact[0]));
    chk("e_pend",  32'(pend_e),  32'(m_pend[0]));
    chk("l_valid", 32'(valid_l), 32'(m_busy[1]));
    chk("l_group", 32'(grp_l),   m_grp[1]);
    chk("l_chan",  32'(chn_l),   m_chn[1]);
    chk("l_gact",  32'(gact_l),  32'(m_gact[1]));
    chk("l_pend",  32'(pend_l),  32'(m_pend[1]));
  endtask

  task automatic ack_and_gap();
    ack_e = 1'b1; step(); ack_e = 1'b0; step(); step();
  endtask

  initial begin
    rst = 1'b1; en = 9'h1FF; req_e = '0; req_l = '0; ack_e = 1'b0; ack_l = 1'b0;
    for (int k = 0; k < 2; k++) model_step(k, '0, 1'b0);
    step();
    chk("rst_valid", 32'(valid_e), 0);
    chk("rst_pend",  32'(pend_e),  0);
    rst = 1'b0;

    // Single request on group 1 channel 5
    req_e[14] = 1'b1; step(); req_e = '0; step();
    chk("s1_valid", 32'(valid_e), 1);
    chk("s1_group", 32'(grp_e),   1);
    chk("s1_chan",  32'(chn_e),   5);
    chk("s1_gact",  32'(gact_e),  32'h2);
    ack_e = 1'b1; step(); ack_e = 1'b0;
    chk("s1_clr",   32'(pend_e[14]), 0);
    chk("s1_drop",  32'(valid_e),    0);
    step(); step();

    // Group priority
    req_e[8] = 1'b1; req_e[20] = 1'b1; step(); req_e = '0; step();
    chk("s2_first_grp", 32'(grp_e), 0);
    chk("s2_first_chn", 32'(chn_e), 8);
    ack_and_gap();
    chk("s2_second_grp", 32'(grp_e), 2);
    chk("s2_second_chn", 32'(chn_e), 2);
    ack_and_gap();

    // Masked pending retained, then released
    en = 9'h1EF; req_e[4] = 1'b1; step(); req_e = '0; step(); step();
    chk("s3_pend", 32'(pend_e[4]), 1);
    chk("s3_novalid", 32'(valid_e), 0);
    chk("s3_gact", 32'(gact_e), 0);
    en = 9'h1FF; step(); step();
    chk("s3_valid", 32'(valid_e), 1);
    chk("s3_chn", 32'(chn_e), 4);
    ack_and_gap();

    // No preemption by a later, higher-priority request
    req_e[18] = 1'b1; step(); req_e = '0; step();
    req_e[8] = 1'b1; step(); req_e = '0; step();
    chk("s4_hold_grp", 32'(grp_e), 2);
    chk("s4_hold_chn", 32'(chn_e), 0);
    ack_and_gap();
    chk("s4_next_grp", 32'(grp_e), 0);
    chk("s4_next_chn", 32'(chn_e), 8);
    ack_and_gap();

    // Set wins over clear in the ack cycle
    req_e[3] = 1'b1; step(); req_e = '0; step();
    ack_e = 1'b1; req_e[3] = 1'b1; step(); ack_e = 1'b0; req_e = '0;
    chk("s5_pend_kept", 32'(pend_e[3]), 1);
    step(); step();
    chk("s5_regrant", 32'(valid_e), 1);
    chk("s5_chn", 32'(chn_e), 3);
    ack_and_gap();

    // Reset during GRANT with a simultaneous ack
    req_e[14] = 1'b1; step(); req_e = '0; step();
    rst = 1'b1; ack_e = 1'b1; step(); rst = 1'b0; ack_e = 1'b0;
    chk("s6_valid", 32'(valid_e), 0);
    chk("s6_pend",  32'(pend_e),  0);
    step(); step();
    chk("s6_quiet", 32'(valid_e), 0);

    // Level mode: held request is re-presented after each gap
    req_l[14] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 10 && !valid_l; i++) step();
      chk("lvl_valid", 32'(valid_l), 1);
      chk("lvl_grp",   32'(grp_l),   1);
      chk("lvl_chn",   32'(chn_l),   5);
      ack_l = 1'b1; step(); ack_l = 1'b0;
    end
    req_l = '0;

    // Randomised traffic on both instances
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = CH'(~($urandom & $urandom & $urandom));
      req_e = NB'($urandom & $urandom & $urandom);
      req_l = NB'($urandom & $urandom & $urandom & $urandom);
      ack_e = $urandom_range(0, 1) == 1;
      ack_l = $urandom_range(0, 2) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
